// File: rtl/mux_8to1_pkg.sv
// Shared constants and helpers for the registered N-to-1 channel selector.
package mux_8to1_pkg;

   localparam int unsigned N_DEFAULT = 8;
   localparam int unsigned W_DEFAULT = 1;

   // Ceiling log2, usable in parameter expressions; returns at least 1 so a select port always exists.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_8to1_sel.sv
// Combinational channel picker: selected channel plus out-of-range flag (channel forced to 0 when out of range).
module mux_8to1_sel
   import mux_8to1_pkg::*;
#(
   parameter int unsigned N     = N_DEFAULT,
   parameter int unsigned W     = W_DEFAULT,
   parameter int unsigned SEL_W = clog2(N)
) (
   input  logic [N*W-1:0] i_in,
   input  logic [SEL_W-1:0] i_sel,
   output logic [W-1:0]   o_ch,
   output logic           o_err
);

   always_comb begin
      o_ch  = '0;
      o_err = 1'b1;
      for (int unsigned k = 0; k < N; k++) begin
         if (i_sel == SEL_W'(k)) begin
            o_ch  = i_in[k*W +: W];
            o_err = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_8to1.sv
// Registered N-to-1 selector with valid qualifier and out-of-range select flag; 1-cycle latency.
module mux_8to1
   import mux_8to1_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT,
   parameter int unsigned W = W_DEFAULT,
   localparam int unsigned SEL_W = clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N*W-1:0]   in,
   input  logic [SEL_W-1:0] sel,
   input  logic             in_valid,
   output logic [W-1:0]     out,
   output logic             out_valid,
   output logic             sel_err
);

   logic [W-1:0] w_ch;
   logic         w_err;
   logic [W-1:0] r_out;
   logic         r_out_valid;
   logic         r_sel_err;

   mux_8to1_sel #(.N(N), .W(W), .SEL_W(SEL_W)) u_sel (
      .i_in  (in),
      .i_sel (sel),
      .o_ch  (w_ch),
      .o_err (w_err)
   );

   // Out-of-range selects already yield a zero channel from the picker.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_sel_err   <= 1'b0;
      end else if (in_valid) begin
         r_out       <= w_ch;
         r_out_valid <= 1'b1;
         r_sel_err   <= w_err;
      end else begin
         r_out_valid <= 1'b0;
         r_sel_err   <= 1'b0;
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_8to1.sv
// Scoreboard bench for mux_8to1: default 8x1 instance and an odd 5x4 instance driven in lockstep.
module tb_mux_8to1;

   typedef struct {
      int        id;
      logic [5:0] val;
      string     tag;
   } exp_t;

   logic        clk;
   logic        rst_n;

   logic [7:0]  a_in;
   logic [2:0]  a_sel;
   logic        a_vld;
   logic [0:0]  a_out;
   logic        a_out_valid;
   logic        a_sel_err;

   logic [19:0] b_in;
   logic [2:0]  b_sel;
   logic        b_vld;
   logic [3:0]  b_out;
   logic        b_out_valid;
   logic        b_sel_err;

   exp_t        exp_q[$];
   logic        m_a;
   logic [3:0]  m_b;
   int          checks;
   int          failures;

   mux_8to1 u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (a_in),
      .sel       (a_sel),
      .in_valid  (a_vld),
      .out       (a_out),
      .out_valid (a_out_valid),
      .sel_err   (a_sel_err)
   );

   mux_8to1 #(.N(5), .W(4)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (b_in),
      .sel       (b_sel),
      .in_valid  (b_vld),
      .out       (b_out),
      .out_valid (b_out_valid),
      .sel_err   (b_sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step(input logic rst, input string tag,
                       input logic va, input logic [7:0] ia, input logic [2:0] sa,
                       input logic vb, input logic [19:0] ib, input logic [2:0] sb);
      exp_t e;
      logic [5:0] obs;
      checks++;
      assert (!(va && $isunknown(sa)) && !(vb && $isunknown(sb))) else begin
         failures++;
         $error("FAIL %s sel_known: observed X on qualified sel, required known", tag);
      end
      rst_n = rst;
      a_vld = va; a_in = ia; a_sel = sa;
      b_vld = vb; b_in = ib; b_sel = sb;

      e.tag = tag;
      e.id  = 0;
      if (!rst) begin
         m_a = 1'b0;
         e.val = {4'h0, 2'b00};
      end else if (va) begin
         m_a = ia[sa];
         e.val = {3'b000, m_a, 2'b10};
      end else begin
         e.val = {3'b000, m_a, 2'b00};
      end
      exp_q.push_back(e);

      e.id = 1;
      if (!rst) begin
         m_b = 4'h0;
         e.val = {4'h0, 2'b00};
      end else if (vb) begin
         if (sb < 3'd5) begin
            m_b = ib[sb*4 +: 4];
            e.val = {m_b, 2'b10};
         end else begin
            m_b = 4'h0;
            e.val = {m_b, 2'b11};
         end
      end else begin
         e.val = {m_b, 2'b00};
      end
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.id == 0) obs = {3'b000, a_out, a_out_valid, a_sel_err};
         else           obs = {b_out, b_out_valid, b_sel_err};
         checks++;
         assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s dut%0d: observed {out,vld,err}=%b required %b", e.tag, e.id, obs, e.val);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_a      = 1'b0;
      m_b      = 4'h0;
      rst_n    = 1'b0;
      a_in = '0; a_sel = '0; a_vld = 1'b0;
      b_in = '0; b_sel = '0; b_vld = 1'b0;

      // Reset dominates a qualified select on both instances.
      step(1'b0, "reset0", 1'b1, 8'h5A, 3'd1, 1'b1, 20'hEDCBA, 3'd2);
      step(1'b0, "reset1", 1'b1, 8'h5A, 3'd1, 1'b1, 20'hEDCBA, 3'd2);
      step(1'b1, "release", 1'b1, 8'h5A, 3'd1, 1'b0, 20'hEDCBA, 3'd2);

      for (int s = 0; s < 8; s++) begin
         step(1'b1, $sformatf("sweep%0d", s), 1'b1, 8'b01011010, 3'(s), 1'b1, 20'hEDCBA, 3'(s));
      end

      step(1'b1, "hold_sel", 1'b1, 8'h5A, 3'd3, 1'b1, 20'hEDCBA, 3'd4);
      step(1'b1, "hold_idle0", 1'b0, 8'h00, 3'd0, 1'b0, 20'h00000, 3'd0);
      step(1'b1, "hold_idle1", 1'b0, 8'h00, 3'd6, 1'b0, 20'h12345, 3'd1);

      step(1'b1, "b2b_ff", 1'b1, 8'hFF, 3'd5, 1'b1, 20'hEDCBA, 3'd2);
      step(1'b1, "b2b_00", 1'b1, 8'h00, 3'd5, 1'b1, 20'hEDCBA, 3'd6);
      step(1'b1, "err_idle", 1'b0, 8'hFF, 3'd5, 1'b0, 20'hEDCBA, 3'd2);
      step(1'b1, "err_then_ok0", 1'b1, 8'h80, 3'd7, 1'b1, 20'hEDCBA, 3'd7);
      step(1'b1, "err_then_ok1", 1'b1, 8'h01, 3'd0, 1'b1, 20'hEDCBA, 3'd0);

      // Reset on the same edge as a qualified select discards it.
      step(1'b1, "pre_mid", 1'b1, 8'hFF, 3'd2, 1'b1, 20'hEDCBA, 3'd3);
      step(1'b0, "mid_reset", 1'b1, 8'hFF, 3'd1, 1'b1, 20'hEDCBA, 3'd3);
      step(1'b1, "post_mid", 1'b0, 8'hFF, 3'd1, 1'b0, 20'hEDCBA, 3'd3);
      step(1'b1, "post_sel", 1'b1, 8'h02, 3'd1, 1'b1, 20'hEDCBA, 3'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_8to1.md
Name: mux_8to1

Overview:
- Registered N-to-1 selector; default configuration is 8 channels of 1 bit each.
- Picks one channel of a packed input bus by index `sel` and presents it on `out` one clock later.
- Used as a generic datapath selection leaf wherever a clocked, resettable channel select is needed.
- Carries a valid qualifier and an out-of-range select flag so it can sit inside handshake pipelines.

Parameters:
- N, 8, number of input channels (≥2).
- W, 1, width of each channel in bits (≥1).
- SEL_W, $clog2(N), width of `sel`; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in  input  N*W  packed channels; channel k occupies bits [k*W +: W].
- sel  input  SEL_W  channel index.
- in_valid  input  1  qualifies `in` and `sel` this cycle.
- out  output  W  registered selected channel.
- out_valid  output  1  `out` updated by a qualified select last cycle.
- sel_err  output  1  last qualified `sel` was ≥ N.

Behaviour:
- All state updates on the rising edge of clk only; no combinational path from inputs to outputs.
- Reset:
  - rst_n=0 at an edge → out=0, out_valid=0, sel_err=0.
  - Reset dominates in_valid.
  - Reset mid-stream discards the pending select.
- Qualified cycle (rst_n=1, in_valid=1):
  - out_valid <= 1.
  - If sel < N: out <= in[sel*W +: W], sel_err <= 0.
  - If sel ≥ N (possible only when N is not a power of 2): out <= 0, sel_err <= 1.
- Idle cycle (rst_n=1, in_valid=0):
  - out holds its previous value.
  - out_valid <= 0, sel_err <= 0.
- Latency exactly 1 cycle from the qualified edge; throughput one select per cycle; back-to-back qualified cycles each produce a result.
- No backpressure; the consumer samples out when out_valid=1.
- `in` and `sel` changing on non-qualified cycles have no effect.
- With default N=8, all 8 `sel` codes are legal and sel_err stays 0.
- X on `sel` during a qualified cycle is a usage error; the bench asserts `sel` is known whenever in_valid=1.

Decomposition:
- Shared package: clog2 helper function, default N/W constants.
- Sub-module mux_8to1_sel, purely combinational. It takes `in` and `sel` and produces the selected channel plus an out-of-range flag.
- The top level adds the registers, reset and valid logic.

Test Plan:
- Sweep: in=8'b01011010, in_valid=1, sel=0..7 one per cycle → out one cycle later = 0,1,0,1,1,0,1,0; out_valid=1; sel_err=0.
- Reset: drive rst_n=0 for 2 cycles with in_valid=1, sel=1 → out=0, out_valid=0; release and select sel=1 → out=1 next cycle.
- Hold: select sel=3 (out=1), then in_valid=0 while changing in to 8'h00 → out stays 1; out_valid=0.
- Back-to-back: in=8'hFF then 8'h00 with sel=5 on consecutive qualified cycles → out=1 then 0 on consecutive cycles.
- Wide/odd config: N=5, W=4, in={4'hE,4'hD,4'hC,4'hB,4'hA} (channel 0 = 4'hA).
  - sel=2 → out=4'hC, sel_err=0.
  - sel=6 → out=0, sel_err=1, out_valid=1.
- Reset mid-stream: qualified sel=1 on the same edge as rst_n=0 → out=0, out_valid=0 after that edge.
